// File: rtl/risc_pkg.sv
// Shared definitions for the veri_Risc memory subsystem: opcodes, default
// bus widths and the host-port arbiter state encoding.
package risc_pkg;

    localparam int AWIDTH_DEF = 5;
    localparam int DWIDTH_DEF = 8;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_t;

    function automatic logic cpu_active(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/risc_mem_arbiter_if.sv
// Host load/inspect port of the memory arbiter: level request held until a
// one-cycle acknowledge, with registered read data.
interface risc_mem_arbiter_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
);
    logic              host_req;
    logic              host_we;
    logic [AWIDTH-1:0] host_addr;
    logic [DWIDTH-1:0] host_wdata;
    logic              host_ack;
    logic [DWIDTH-1:0] host_rdata;
    logic              host_busy;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata, host_busy
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata, host_busy
    );
endinterface

// File: rtl/risc_mem_arbiter_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_r;

    // Clear wins over enable; counting stops at the maximum value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (en && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
endmodule

// File: rtl/risc_mem_arbiter.sv
// Shares the single program/data memory between the CPU (absolute priority,
// never stalled) and a host port that only uses cycles the CPU leaves idle.
module risc_mem_arbiter
    import risc_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int WAIT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [DWIDTH-1:0] cpu_rdata,
    risc_mem_arbiter_if.slave host,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic              conflict_err,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DWIDTH-1:0] mem_rdata
);
    arb_state_t        state_r;
    arb_state_t        next_s;
    logic              we_r;
    logic [AWIDTH-1:0] addr_r;
    logic [DWIDTH-1:0] wdata_r;
    logic [DWIDTH-1:0] rdata_r;
    logic              conflict_r;
    logic              cpu_act_s;
    logic              grant_s;
    logic              accept_s;

    assign cpu_act_s = cpu_active(cpu_rd, cpu_wr);
    assign grant_s   = (state_r == ST_WAIT) && !cpu_act_s;
    assign accept_s  = (state_r == ST_IDLE) && host.host_req;

    // State register; an async reset drops any pending host access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // ACK always returns to IDLE so a held request costs a full 3-cycle turn.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (host.host_req) next_s = ST_WAIT;
                else               next_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (grant_s) next_s = ST_ACK;
                else         next_s = ST_WAIT;
            end
            ST_ACK:  next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // Request fields are captured only when a request is accepted from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r    <= 1'b0;
            addr_r  <= {AWIDTH{1'b0}};
            wdata_r <= {DWIDTH{1'b0}};
        end else if (accept_s) begin
            we_r    <= host.host_we;
            addr_r  <= host.host_addr;
            wdata_r <= host.host_wdata;
        end else begin
            we_r    <= we_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Read data is held until the next host read completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= {DWIDTH{1'b0}};
        end else if (grant_s && !we_r) begin
            rdata_r <= mem_rdata;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // Sticky flag for a CPU that strobes read and write together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_r <= 1'b0;
        end else if (cpu_rd && cpu_wr) begin
            conflict_r <= 1'b1;
        end else begin
            conflict_r <= conflict_r;
        end
    end

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept_s),
        .en  ((state_r == ST_WAIT) && cpu_act_s),
        .cnt (wait_cnt)
    );

    // Host owns the bus only in WAIT with the CPU idle; CPU strobes pass as-is.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        if (grant_s) begin
            mem_addr  = addr_r;
            mem_wdata = wdata_r;
            mem_rd    = !we_r;
            mem_wr    = we_r;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_rd    = cpu_rd;
            mem_wr    = cpu_wr;
        end
    end

    assign cpu_rdata       = mem_rdata;
    assign host.host_ack   = (state_r == ST_ACK);
    assign host.host_busy  = (state_r != ST_IDLE);
    assign host.host_rdata = rdata_r;
    assign conflict_err    = conflict_r;
endmodule

// File: tb/tb_risc_mem_arbiter.sv
// Directed bench for risc_mem_arbiter with a 32x8 memory model on the bus.
module tb_risc_mem_arbiter;
    import risc_pkg::*;

    logic       clk;
    logic       rst;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_rd;
    logic       cpu_wr;
    logic [7:0] cpu_rdata;
    logic [7:0] wait_cnt;
    logic       conflict_err;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_rdata;
    logic [7:0] mem [32];

    int n_vec;
    int n_miss;

    risc_mem_arbiter_if #(.AWIDTH(5), .DWIDTH(8)) host ();

    risc_mem_arbiter #(.AWIDTH(5), .DWIDTH(8), .WAIT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rd       (cpu_rd),
        .cpu_wr       (cpu_wr),
        .cpu_rdata    (cpu_rdata),
        .host         (host.slave),
        .wait_cnt     (wait_cnt),
        .conflict_err (conflict_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one host access with the CPU idle; returns edges from request to ack.
    task automatic host_xfer(input logic we, input logic [4:0] addr,
                             input logic [7:0] wdata, output int cycles);
        host.host_req   = 1'b1;
        host.host_we    = we;
        host.host_addr  = addr;
        host.host_wdata = wdata;
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!host.host_ack && cycles < 50);
        if (!host.host_ack) check("ack_timeout", 32'd0, 32'd1);
        host.host_req = 1'b0;
        tick();
    endtask

    int cyc;
    int gap;

    initial begin
        n_vec = 0;
        n_miss = 0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        rst = 1'b1;
        cpu_addr = 5'd9;
        cpu_wdata = 8'h00;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        host.host_req = 1'b0;
        host.host_we = 1'b0;
        host.host_addr = 5'd0;
        host.host_wdata = 8'h00;
        tick();
        tick();
        check("rst_ack", {31'd0, host.host_ack}, 32'd0);
        check("rst_busy", {31'd0, host.host_busy}, 32'd0);
        check("rst_conflict", {31'd0, conflict_err}, 32'd0);
        check("rst_rdata", {24'd0, host.host_rdata}, 32'd0);
        check("rst_wait", {24'd0, wait_cnt}, 32'd0);
        check("rst_mem_addr", {27'd0, mem_addr}, 32'd9);
        rst = 1'b0;
        tick();

        // Write then read back with the CPU idle.
        host_xfer(1'b1, 5'd3, 8'hA5, cyc);
        check("wr_latency", cyc, 32'd2);
        check("wr_mem3", {24'd0, mem[3]}, 32'h0000_00A5);
        host_xfer(1'b0, 5'd3, 8'h00, cyc);
        check("rd_latency", cyc, 32'd2);
        check("rd_data", {24'd0, host.host_rdata}, 32'h0000_00A5);
        check("rd_wait", {24'd0, wait_cnt}, 32'd0);

        // Host read of addr 7 blocked by 5 CPU read cycles.
        host_xfer(1'b1, 5'd7, 8'h5A, cyc);
        cpu_addr = 5'd20;
        host.host_req = 1'b1;
        host.host_we = 1'b0;
        host.host_addr = 5'd7;
        tick();
        check("blk_busy", {31'd0, host.host_busy}, 32'd1);
        cpu_rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("blk_mem_addr", {27'd0, mem_addr}, 32'd20);
            check("blk_no_ack", {31'd0, host.host_ack}, 32'd0);
            tick();
        end
        cpu_rd = 1'b0;
        #1;
        check("blk_grant_addr", {27'd0, mem_addr}, 32'd7);
        check("blk_grant_rd", {30'd0, mem_rd, mem_wr}, 32'd2);
        tick();
        check("blk_ack", {31'd0, host.host_ack}, 32'd1);
        check("blk_rdata", {24'd0, host.host_rdata}, 32'h0000_005A);
        check("blk_wait", {24'd0, wait_cnt}, 32'd5);
        host.host_req = 1'b0;
        tick();

        // Program load {JMP 2, JMP 2, HLT} and readback.
        host_xfer(1'b1, 5'd0, {JMP, 5'd2}, cyc);
        host_xfer(1'b1, 5'd1, {JMP, 5'd2}, cyc);
        host_xfer(1'b1, 5'd2, {HLT, 5'd0}, cyc);
        host_xfer(1'b0, 5'd1, 8'h00, cyc);
        check("prog_rd1", {24'd0, host.host_rdata}, 32'h0000_00E2);
        check("prog_mem2", {24'd0, mem[2]}, 32'd0);

        // Saturation of the wait counter under a long CPU burst.
        host.host_req = 1'b1;
        host.host_we = 1'b0;
        host.host_addr = 5'd3;
        tick();
        cpu_rd = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        check("sat_wait", {24'd0, wait_cnt}, 32'd255);
        cpu_rd = 1'b0;
        tick();
        check("sat_ack", {31'd0, host.host_ack}, 32'd1);
        host.host_req = 1'b0;
        tick();

        // Async reset during a granted host write.
        host.host_req = 1'b1;
        host.host_we = 1'b1;
        host.host_addr = 5'd4;
        host.host_wdata = 8'h3C;
        tick();
        host.host_req = 1'b0;
        check("rstmid_mem_wr_pre", {31'd0, mem_wr}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rstmid_busy", {31'd0, host.host_busy}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstmid_no_ack", {31'd0, host.host_ack}, 32'd0);
            tick();
        end
        check("rstmid_mem4", {24'd0, mem[4]}, 32'd0);

        // Conflicting CPU strobes are forwarded and flagged until reset.
        cpu_addr = 5'd31;
        cpu_rd = 1'b1;
        cpu_wr = 1'b1;
        #1;
        check("conf_fwd", {30'd0, mem_rd, mem_wr}, 32'd3);
        tick();
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        check("conf_set", {31'd0, conflict_err}, 32'd1);
        tick();
        tick();
        tick();
        check("conf_sticky", {31'd0, conflict_err}, 32'd1);
        rst = 1'b1;
        #1;
        check("conf_clear", {31'd0, conflict_err}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Request held through ACK yields exactly two acks 3 cycles apart.
        host.host_req = 1'b1;
        host.host_we = 1'b1;
        host.host_addr = 5'd10;
        host.host_wdata = 8'h11;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!host.host_ack && cyc < 50);
        check("held_first", cyc, 32'd2);
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!host.host_ack && gap < 50);
        check("held_gap", gap, 32'd3);
        host.host_req = 1'b0;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (host.host_ack) cyc++;
        end
        check("held_no_third", cyc, 32'd0);
        check("held_mem10", {24'd0, mem[10]}, 32'h0000_0011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/risc_mem_arbiter.md
# risc_mem_arbiter

Arbitrates the single 32x8 program/data memory of `veri_Risc` between the CPU datapath and a host load/inspect port. The host can load programs and read results through the port instead of writing memory by hierarchical reference. The CPU always has absolute priority and is never stalled. Host accesses are scheduled into cycles in which the CPU issues neither a read nor a write, and each completes with a one-cycle acknowledge.

## Interface
- `AWIDTH`, default 5: memory address width.
- `DWIDTH`, default 8: memory data width.
- `WAIT_W`, default 8: width of the saturating wait counter.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cpu_addr` in AWIDTH: CPU memory address.
- `cpu_wdata` in DWIDTH: CPU write data (accumulator).
- `cpu_rd` in 1: CPU read strobe.
- `cpu_wr` in 1: CPU write strobe.
- `cpu_rdata` out DWIDTH: memory read data returned to the CPU (combinational pass-through).
- `host_req` in 1: host request; level, held until `host_ack`.
- `host_we` in 1: 1 = write, 0 = read.
- `host_addr` in AWIDTH: host address.
- `host_wdata` in DWIDTH: host write data.
- `host_ack` out 1: one-cycle completion pulse.
- `host_rdata` out DWIDTH: registered read data; valid from `host_ack` until the next read completes.
- `host_busy` out 1: a request is latched and not yet acknowledged.
- `wait_cnt` out WAIT_W: cycles the current or last request spent blocked by the CPU; saturates.
- `conflict_err` out 1: sticky; set when the CPU asserts `cpu_rd` and `cpu_wr` in the same cycle.
- `mem_addr` out AWIDTH: address to memory.
- `mem_wdata` out DWIDTH: write data to memory.
- `mem_rd` out 1: memory read enable.
- `mem_wr` out 1: memory write enable; memory writes on the rising edge.
- `mem_rdata` in DWIDTH: combinational memory read data.

## Operation
- **States:** IDLE, WAIT, ACK.
- **IDLE:**
  - If `host_req` = 1 at the edge: latch `host_we`, `host_addr` and `host_wdata`; clear `wait_cnt`; go to WAIT.
  - `host_busy` = 0.
- **WAIT:** `host_busy` = 1.
  - CPU active (`cpu_rd` or `cpu_wr` = 1): the memory bus carries the CPU request and `wait_cnt` increments, saturating at 2^WAIT_W-1.
  - CPU idle:
    - The memory bus carries the latched host request: `mem_rd` = !we, `mem_wr` = we.
    - At the edge, a read captures `mem_rdata` into `host_rdata`; a write is performed by memory.
    - Go to ACK.
- **ACK:**
  - `host_ack` = 1 for exactly one cycle; `host_busy` = 1.
  - Go to IDLE unconditionally. `host_req` is not sampled in ACK.
  - The host must deassert `host_req` in the ACK cycle or it is taken as a new request in IDLE.
- **Bus mux:**
  - Combinational. The host owns `mem_*` only in WAIT with the CPU idle; otherwise the CPU owns it.
  - `mem_rd` and `mem_wr` are never both 1 from a host access.
  - `cpu_rdata` = `mem_rdata` at all times.
- **Conflict:** `cpu_rd` and `cpu_wr` both high sets `conflict_err`, which only `rst` clears. The CPU strobes are still forwarded unmodified.
- **Host request fields:** ignored outside IDLE.

## Timing
- **Reset values:**
  - State IDLE.
  - `host_ack`, `host_busy`, `conflict_err` = 0.
  - `host_rdata` = 0, `wait_cnt` = 0.
  - `mem_*` follow the CPU inputs.
- **Latency:**
  - `host_req` sampled at edge k with the CPU idle in cycle k→k+1: access completes at edge k+1, and `host_ack` is high in cycle k+1→k+2.
  - Each CPU-active cycle in WAIT adds one cycle.
- **Throughput:** at most one host access every 3 cycles.
- **Reset mid-operation:**
  - Asynchronous `rst` returns the block to IDLE immediately.
  - `mem_wr` from the host drops in the same cycle, so no write occurs.
  - A pending request is discarded and never acknowledged.
- **Simultaneous events:** the CPU strobe rising in the same cycle the host would be granted means the CPU wins and the host stays in WAIT.

## Structure
- Shared package `risc_pkg`:
  - Opcode constants HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP.
  - Default AWIDTH/DWIDTH.
  - Arbiter state encoding.
- One natural sub-module: `sat_counter` (parameterised width, clear, enable, saturate), used for `wait_cnt`.

## Test plan
- **Write/read with CPU idle:** host writes addr 3 = 8'hA5 → `host_ack` 2 cycles after the request. A read of addr 3 then returns `host_rdata` = 8'hA5 and `wait_cnt` = 0.
- **CPU blocking:** `cpu_rd` held for 5 cycles while a host read of addr 7 is pending → `mem_addr` = `cpu_addr` throughout. The ack is delayed exactly 5 cycles, with `wait_cnt` = 5.
- **Program load:** with CPU `rst` held, load {JMP 2, JMP 2, HLT} via the host port, then release reset → `halt` = 0 after 10 clocks and 1 after 11.
- **Reset mid-operation:** assert `rst` in WAIT with a host write of 8'h3C to addr 4 pending → addr 4 is unchanged, no `host_ack`, `host_busy` = 0.
- **Conflict:** `cpu_rd` = `cpu_wr` = 1 for one cycle → `conflict_err` = 1 and remains 1 until `rst`.
- **Held request:** keep `host_req` high through ACK → exactly one new access starts from IDLE, giving two acks 3 cycles apart.
